// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// State encoding, default width and small state helpers.
package serial_sub_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SUB  = 2'b01,
    NEG  = 2'b10,
    DONE = 2'b11
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == SUB) || (s == NEG);
  endfunction

endpackage

// File: rtl/serial_sub_fs.sv
// Single-bit full subtractor cell.
// d = a - b - bin, bout set when the bit underflows.
module fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor, LSB first, one cell.
// A negative result is negated serially to form |A - B|.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] D,
  output logic         Bout,
  output logic [N-1:0] Mag,
  output logic         Busy,
  output logic         Done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  sa;
  logic [N-1:0]  sb;
  logic [N-2:0]  sr;
  logic [CW-1:0] cnt;
  logic          brw;
  logic          cell_a;
  logic          cell_b;
  logic          cell_d;
  logic          cell_bo;
  logic          last;
  logic [N-1:0]  res;

  // Cell operands: minuend bit in SUB, zero in NEG.
  always_comb begin
    cell_a = (state == SUB) ? sa[0] : 1'b0;
    cell_b = sb[0];
    last   = (cnt == LAST);
    res    = {cell_d, sr};
  end

  fs u_fs (
    .a    (cell_a),
    .b    (cell_b),
    .bin  (brw),
    .d    (cell_d),
    .bout (cell_bo)
  );

  // Next-state decode; SUB exit depends on the final borrow.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (Start) state_nxt = SUB;
      SUB:  if (last) state_nxt = cell_bo ? NEG : DONE;
      NEG:  if (last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, shift datapath and registered results.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      cnt   <= '0;
      brw   <= 1'b0;
      D     <= '0;
      Bout  <= 1'b0;
      Mag   <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= state_nxt;
      Busy  <= is_busy(state_nxt);
      Done  <= (state_nxt == DONE);
      unique case (state)
        IDLE: begin
          if (Start) begin
            sa  <= A;
            sb  <= B;
            sr  <= '0;
            cnt <= '0;
            brw <= 1'b0;
          end
        end
        SUB: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= res[N-1:1];
          brw <= cell_bo;
          cnt <= cnt + CW'(1);
          if (last) begin
            cnt <= '0;
            brw <= 1'b0;
            if (cell_bo) begin
              // Keep the raw difference in sa, negate it from sb.
              sa <= res;
              sb <= res;
              sr <= '0;
            end else begin
              D    <= res;
              Bout <= 1'b0;
              Mag  <= res;
            end
          end
        end
        NEG: begin
          sb  <= sb >> 1;
          sr  <= res[N-1:1];
          brw <= cell_bo;
          cnt <= cnt + CW'(1);
          if (last) begin
            cnt  <= '0;
            brw  <= 1'b0;
            D    <= sa;
            Bout <= 1'b1;
            Mag  <= res;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (N=8).
// Random and directed operations against an arithmetic model.
module tb_serial_sub;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] d;
  logic         bout;
  logic [N-1:0] mag;
  logic         busy;
  logic         done;

  int total;
  int bad;

  serial_sub #(.N(N)) dut (
    .Clock (clk),
    .Reset (rst),
    .Start (start),
    .A     (a),
    .B     (b),
    .D     (d),
    .Bout  (bout),
    .Mag   (mag),
    .Busy  (busy),
    .Done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] m_diff(input int x, input int y);
    int r;
    r = (x - y) % (1 << N);
    if (r < 0) r += (1 << N);
    return N'(r);
  endfunction

  function automatic logic m_bout(input int x, input int y);
    return x < y;
  endfunction

  function automatic logic [N-1:0] m_mag(input int x, input int y);
    return (x >= y) ? N'(x - y) : N'(y - x);
  endfunction

  function automatic int m_lat(input int x, input int y);
    return (x < y) ? 2 * N : N;
  endfunction

  // Issue one operation; report outputs at Done, latency and extras.
  task automatic run_op(
    input  logic [N-1:0] xa,
    input  logic [N-1:0] xb,
    input  bit           scramble,
    output logic [N-1:0] od,
    output logic         obo,
    output logic [N-1:0] om,
    output int           lat,
    output bit           busy_ok,
    output int           extra
  );
    @(negedge clk);
    start = 1'b1;
    a = xa;
    b = xb;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    extra = 0;
    while (!done && lat < 4 * N) begin
      if (!busy) busy_ok = 1'b0;
      if (scramble) begin
        start = 1'($urandom);
        a = N'($urandom);
        b = N'($urandom);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    od = d;
    obo = bout;
    om = mag;
    if (!done) lat = -1;
    for (int i = 0; i < N + 3; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({d, bout, mag, busy, done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got d=%0d bo=%0b m=%0d busy=%0b done=%0b want all 0",
               d, bout, mag, busy, done);
    end
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle busy=%0b want 0", busy);
    end
  endtask

  task automatic test_directed;
    logic [N-1:0] od;
    logic [N-1:0] om;
    logic         obo;
    int           lat;
    bit           bok;
    int           ex;
    int           va[4] = '{200, 55, 0, 128};
    int           vb[4] = '{55, 200, 1, 128};
    for (int k = 0; k < 4; k++) begin
      run_op(N'(va[k]), N'(vb[k]), 1'b0, od, obo, om, lat, bok, ex);
      total++;
      if (od !== m_diff(va[k], vb[k]) || obo !== m_bout(va[k], vb[k])
          || om !== m_mag(va[k], vb[k])) begin
        bad++;
        $display("FAIL directed_%0d got d=%0d bo=%0b m=%0d want d=%0d bo=%0b m=%0d",
                 k, od, obo, om, m_diff(va[k], vb[k]), m_bout(va[k], vb[k]),
                 m_mag(va[k], vb[k]));
      end
      total++;
      if (lat !== m_lat(va[k], vb[k]) || !bok || ex !== 0) begin
        bad++;
        $display("FAIL directed_timing_%0d got lat=%0d busy_ok=%0b extra=%0d want lat=%0d 1 0",
                 k, lat, bok, ex, m_lat(va[k], vb[k]));
      end
    end
  endtask

  task automatic test_ignore_inputs;
    logic [N-1:0] od;
    logic [N-1:0] om;
    logic         obo;
    int           lat;
    bit           bok;
    int           ex;
    run_op(N'(10), N'(3), 1'b1, od, obo, om, lat, bok, ex);
    total++;
    if (od !== N'(7) || om !== N'(7) || obo !== 1'b0) begin
      bad++;
      $display("FAIL ignore_result got d=%0d m=%0d bo=%0b want 7 7 0", od, om, obo);
    end
    total++;
    if (lat !== N || ex !== 0 || !bok) begin
      bad++;
      $display("FAIL ignore_timing got lat=%0d extra=%0d busy_ok=%0b want %0d 0 1",
               lat, ex, bok, N);
    end
  endtask

  task automatic test_abort;
    logic [N-1:0] od;
    logic [N-1:0] om;
    logic         obo;
    int           lat;
    bit           bok;
    int           ex;
    int           pts[2] = '{4, 12};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 1'b1;
      a = N'(5);
      b = N'(9);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (pts[k] - 1) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      total++;
      if ({d, bout, mag, busy, done} !== '0) begin
        bad++;
        $display("FAIL abort_%0d got d=%0d bo=%0b m=%0d busy=%0b done=%0b want all 0",
                 pts[k], d, bout, mag, busy, done);
      end
      ex = 0;
      for (int i = 0; i < 2 * N + 2; i++) begin
        @(posedge clk);
        #1;
        if (done || busy || d !== '0 || mag !== '0) ex++;
      end
      total++;
      if (ex !== 0) begin
        bad++;
        $display("FAIL abort_quiet_%0d got %0d active cycles want 0", pts[k], ex);
      end
      run_op(N'(9), N'(5), 1'b0, od, obo, om, lat, bok, ex);
      total++;
      if (od !== N'(4) || om !== N'(4) || obo !== 1'b0 || lat !== N) begin
        bad++;
        $display("FAIL abort_restart_%0d got d=%0d m=%0d bo=%0b lat=%0d want 4 4 0 %0d",
                 pts[k], od, om, obo, lat, N);
      end
    end
  endtask

  task automatic test_random;
    logic [N-1:0] od;
    logic [N-1:0] om;
    logic         obo;
    logic [N-1:0] xa;
    logic [N-1:0] xb;
    int           lat;
    bit           bok;
    int           ex;
    for (int k = 0; k < 24; k++) begin
      xa = N'($urandom);
      xb = (k % 6 == 5) ? xa : N'($urandom);
      run_op(xa, xb, k[0], od, obo, om, lat, bok, ex);
      total++;
      if (od !== m_diff(int'(xa), int'(xb)) || obo !== m_bout(int'(xa), int'(xb))
          || om !== m_mag(int'(xa), int'(xb))) begin
        bad++;
        $display("FAIL random_%0d a=%0d b=%0d got d=%0d bo=%0b m=%0d want d=%0d bo=%0b m=%0d",
                 k, xa, xb, od, obo, om, m_diff(int'(xa), int'(xb)),
                 m_bout(int'(xa), int'(xb)), m_mag(int'(xa), int'(xb)));
      end
      total++;
      if (lat !== m_lat(int'(xa), int'(xb)) || !bok || ex !== 0) begin
        bad++;
        $display("FAIL random_timing_%0d got lat=%0d busy_ok=%0b extra=%0d want lat=%0d",
                 k, lat, bok, ex, m_lat(int'(xa), int'(xb)));
      end
      total++;
      if (d !== od || mag !== om || bout !== obo) begin
        bad++;
        $display("FAIL random_hold_%0d got d=%0d m=%0d bo=%0b want %0d %0d %0b",
                 k, d, mag, bout, od, om, obo);
      end
    end
  endtask

  task automatic test_back_to_back;
    int when[$];
    int bad_val;
    int cyc;
    bad_val = 0;
    cyc = 0;
    @(negedge clk);
    start = 1'b1;
    a = N'(200);
    b = N'(55);
    while (when.size() < 3 && cyc < 10 * N) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        when.push_back(cyc);
        if (d !== N'(145) || mag !== N'(145) || bout !== 1'b0) bad_val++;
      end
    end
    start = 1'b0;
    repeat (2 * N + 4) @(posedge clk);
    #1;
    total++;
    if (when.size() !== 3 || bad_val !== 0) begin
      bad++;
      $display("FAIL b2b_pulses got %0d pulses, %0d bad values want 3, 0",
               when.size(), bad_val);
    end
    total++;
    if (when.size() == 3
        && (when[1] - when[0] !== N + 2 || when[2] - when[1] !== N + 2)) begin
      bad++;
      $display("FAIL b2b_spacing got %0d,%0d want %0d", when[1] - when[0],
               when[2] - when[1], N + 2);
    end else if (when.size() != 3) begin
      bad++;
      $display("FAIL b2b_spacing got too few pulses (%0d) want 3", when.size());
    end
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain busy=%0b done=%0b want 0 0", busy, done);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    test_reset;
    test_directed;
    test_ignore_inputs;
    test_abort;
    test_random;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
